fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage and feeds it `instruction` and the incremented PC. Owns the program counter, drives a request/acknowledge instruction-memory port, and holds a one-entry buffer for data returning while the pipe is frozen. Consumes `brTaken`/`brAddr` from downstream to redirect and flush.

---
 rtl/fetch_stage_pkg.sv | 6 +
 rtl/fetch_stage_if.sv | 9 +
 rtl/fetch_stage_pc_register.sv | 15 +
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared state encoding and constants for the fetch stage
package fetch_stage_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: request/acknowledge instruction-memory port
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_stage_pc_register.sv
// pc_register: 32-bit register with load enable and async active-low reset
module pc_register #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);
    // load on enable, otherwise hold
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= RESET_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem request FSM, hold buffer and IF/ID register; FETCH_STALL_CNT_EN adds stall_cnt
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 brTaken,
    input  logic [31:0]          brAddr,
    fetch_stage_if.master        imem,
    output logic [31:0]          instruction,
    output logic [31:0]          PC,
    output logic                 valid
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);
    fetch_state_t state, state_d;
    logic [31:0]  fetch_pc, pc_d, pc_inc, req_addr, hold_instr, hold_pc;
    logic         pc_load, outstanding, kill, acc, live;

    pc_register #(.RESET_VAL(RESET_PC)) u_pc (
        .clk(clk),
        .rst(rst),
        .en (pc_load),
        .d  (pc_d),
        .q  (fetch_pc)
    );

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_d;

    // next state and request outputs; a branch suppresses a fresh request so the redirect lands next cycle
    always_comb begin
        imem.addr = outstanding ? req_addr : fetch_pc;
        imem.req  = (state == REQ) && (outstanding || (!freeze && !brTaken));
        acc       = imem.req && imem.ack;
        live      = acc && !kill && !brTaken;
        pc_inc    = fetch_pc + PC_STEP;
        pc_load   = brTaken || live;
        pc_d      = brTaken ? (brAddr & ~32'h3) : pc_inc;
        state_d   = state == IDLE ? REQ :
                    state == REQ  ? ((live && freeze) ? HOLD : REQ) :
                    ((brTaken || !freeze) ? REQ : HOLD);
    end

    // outstanding-request tracking; kill marks an in-flight request whose data must be dropped
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            outstanding <= 1'b0;
            req_addr    <= RESET_PC;
            kill        <= 1'b0;
        end else begin
            outstanding <= imem.req && !imem.ack;
            req_addr    <= imem.addr;
            kill        <= (kill || (brTaken && outstanding)) && !acc;
        end

    // hold buffer captures a word that returns while the pipe is frozen
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            hold_instr <= NOP_INSTR;
            hold_pc    <= 32'h0;
        end else if (live && freeze) begin
            hold_instr <= imem.rdata;
            hold_pc    <= pc_inc;
        end

    // IF/ID register: branch flushes, freeze holds, otherwise load buffer/new word or insert a bubble
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            instruction <= NOP_INSTR;
            PC          <= 32'h0;
            valid       <= 1'b0;
        end else if (brTaken) begin
            instruction <= NOP_INSTR;
            PC          <= 32'h0;
            valid       <= 1'b0;
        end else if (!freeze) begin
            instruction <= state == HOLD ? hold_instr : live ? imem.rdata : NOP_INSTR;
            PC          <= state == HOLD ? hold_pc : live ? pc_inc : 32'h0;
            valid       <= state == HOLD || live;
        end

`ifdef FETCH_STALL_CNT_EN
    // saturating count of cycles where decode gets nothing new
    always_ff @(posedge clk or negedge rst)
        if (!rst) stall_cnt <= 16'h0;
        else if ((freeze || !valid) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard queue checked by an independent IF/ID monitor
module tb_fetch_stage;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        brTaken = 1'b0;
    logic [31:0] brAddr = 32'h0;
    logic        ack = 1'b0;
    logic        ovr = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    logic [31:0] instruction, PC;
    logic        valid;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int          passed = 0;
    int          total = 0;
    exp_t        q[$];

    fetch_stage_if imem();

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem.ack   = ack;
    assign imem.rdata = ovr ? ovr_data : mem(imem.addr);

    fetch_stage dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .brTaken(brTaken),
        .brAddr(brAddr),
        .imem(imem),
        .instruction(instruction),
        .PC(PC),
        .valid(valid)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        q.push_back('{instr: i, pc: p});
    endtask

    task automatic step(input logic f, input logic b, input logic [31:0] ba,
                        input logic a, input logic [31:0] d);
        @(posedge clk);
        #1;
        freeze = f;
        brTaken = b;
        brAddr = ba;
        ack = a;
        ovr = (d != 32'h0);
        ovr_data = d;
        @(negedge clk);
    endtask

    task automatic chk_req(input logic r, input logic [31:0] a);
        chk("imem_req", 32'(imem.req), 32'(r));
        if (r) chk("imem_addr", imem.addr, a);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", 32'(imem.req), 32'h0);
        chk("rst_addr", imem.addr, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
    endtask

    // monitor: decode consumes IF/ID whenever it is live, not frozen and not being flushed
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && valid && !freeze && !brTaken) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_issue: got instr %h pc %h expected none", instruction, PC);
                end else begin
                    e = q.pop_front();
                    chk("ifid_instr", instruction, e.instr);
                    chk("ifid_pc", PC, e.pc);
                end
            end
        end
    end

    initial begin
        #2 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        ack = 1'b1;
        @(negedge clk);
        chk_req(L, 32'h0);
        // zero-wait fetches at 0 and 4
        step(L, L, 32'h0, H, 32'h0); chk_req(H, 32'h0); push(mem(32'h0), 32'h4);
        step(L, L, 32'h0, H, 32'h0); chk_req(H, 32'h4); push(mem(32'h4), 32'h8);
        // ack delayed three cycles on address 8
        step(L, L, 32'h0, L, 32'h0); chk_req(H, 32'h8);
        step(L, L, 32'h0, L, 32'h0); chk_req(H, 32'h8); chk("bubble_valid", 32'(valid), 32'h0);
        step(L, L, 32'h0, L, 32'h0); chk_req(H, 32'h8); chk("bubble_valid", 32'(valid), 32'h0);
        step(L, L, 32'h0, H, 32'h0); chk_req(H, 32'h8); chk("bubble_valid", 32'(valid), 32'h0);
        push(mem(32'h8), 32'hC);
        step(L, L, 32'h0, H, 32'h0); chk_req(H, 32'hC); push(mem(32'hC), 32'h10);
        // freeze while 16 is outstanding; ack lands in the hold buffer
        step(L, L, 32'h0, L, 32'h0); chk_req(H, 32'h10);
        step(H, L, 32'h0, H, 32'hDEAD_BEEF); chk_req(H, 32'h10); push(32'hDEAD_BEEF, 32'h14);
        step(H, L, 32'h0, L, 32'h0); chk_req(L, 32'h0); chk("frozen_valid", 32'(valid), 32'h0);
        step(L, L, 32'h0, L, 32'h0); chk_req(L, 32'h0);
        step(L, L, 32'h0, H, 32'h0); chk_req(H, 32'h14); push(mem(32'h14), 32'h18);
        // branch to 0x43 (low bits ignored) while 24 is outstanding
        step(L, L, 32'h0, L, 32'h0); chk_req(H, 32'h18);
        step(L, H, 32'h43, L, 32'h0); chk_req(H, 32'h18);
        step(L, L, 32'h0, H, 32'h0BAD_0BAD); chk_req(H, 32'h18);
        step(L, L, 32'h0, H, 32'h0); chk_req(H, 32'h40); chk("killed_valid", 32'(valid), 32'h0);
        push(mem(32'h40), 32'h44);
        // fill the hold buffer, then branch and freeze together
        step(L, L, 32'h0, L, 32'h0); chk_req(H, 32'h44);
        step(H, L, 32'h0, H, 32'h0); chk_req(H, 32'h44);
        step(H, H, 32'h80, L, 32'h0); chk_req(L, 32'h0);
        step(L, L, 32'h0, H, 32'h0); chk_req(H, 32'h80);
        chk("flush_instr", instruction, 32'h0); chk("flush_valid", 32'(valid), 32'h0);
        push(mem(32'h80), 32'h84);
        step(L, L, 32'h0, L, 32'h0); chk_req(H, 32'h84);
        // reset in the middle of an outstanding request
        @(posedge clk);
        #1;
        rst = 1'b0;
        ack = 1'b1;
        #1;
        chk_reset_outputs();
        // branch in IDLE to the top of memory, then wrap to 0
        @(posedge clk);
        #1;
        rst = 1'b1;
        brTaken = 1'b1;
        brAddr = 32'hFFFF_FFFC;
        ack = 1'b0;
        @(negedge clk);
        chk_req(L, 32'h0);
        step(L, L, 32'h0, H, 32'h0); chk_req(H, 32'hFFFF_FFFC); push(mem(32'hFFFF_FFFC), 32'h0);
        step(L, L, 32'h0, L, 32'h0); chk_req(H, 32'h0);
        // fresh reset: two empty cycles, then five frozen cycles
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        ack = 1'b1;
        @(negedge clk);
        step(L, L, 32'h0, H, 32'h0); chk_req(H, 32'h0); push(mem(32'h0), 32'h4);
        step(H, L, 32'h0, L, 32'h0); chk_req(L, 32'h0);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt_empty", 32'(stall_cnt), 32'd2);
`endif
        for (int i = 0; i < 4; i++) step(H, L, 32'h0, L, 32'h0);
        step(L, L, 32'h0, L, 32'h0); chk_req(H, 32'h4);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt_frozen", 32'(stall_cnt), 32'd7);
`endif
        step(L, L, 32'h0, H, 32'h0); chk_req(H, 32'h4); push(mem(32'h4), 32'h8);
        step(L, L, 32'h0, L, 32'h0);
        step(L, L, 32'h0, L, 32'h0);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
